pix_stream_fifo: RTL and testbench
==================================

PIX_STREAM_FIFO -- requirements
Module: pix_stream_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, minimum 4.
REQ-002 SHALL have parameter THRESH, default 8, occupancy required before streaming starts; range 1..DEPTH.
REQ-003 SHALL have parameter UNDER_COLOUR, default 8'hC0, RRGGBBxx pixel emitted on underflow and before streaming starts.
REQ-004 SHALL have port clk_pix  input  1  pixel clock; the only clock.
REQ-005 SHALL have port rst_pix_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_data  input  8  RRGGBBxx pixel from PPU data_o.
REQ-007 SHALL have port in_stb  input  1  producer strobe, pixel offered.
REQ-008 SHALL have port in_ack  output  1  pixel accepted; a transfer occurs on a cycle with in_stb and in_ack both high.
REQ-009 SHALL have port frame_start  input  1  one-cycle pulse that flushes the FIFO and starts prefill.
REQ-010 SHALL have port de  input  1  display data enable from vga_driver.
REQ-011 SHALL have port pix_out  output  8  pixel to vga_driver wb_data.
REQ-012 SHALL have port level  output  $clog2(DEPTH)+1  current occupancy.
REQ-013 SHALL have port underflow_cnt  output  16  count of underflow events, saturating.
REQ-014 SHALL have port state_o  output  2  current state encoding, for debug.

Function
REQ-015 SHALL implement states IDLE=0, PREFILL=1, STREAM=2, STARVED=3.
REQ-016 IDLE: in_ack=0, no pops; frame_start -> PREFILL.
REQ-017 frame_start SHALL have priority over all other events in every state: pointers and level clear, in_ack=0 that cycle, in_stb ignored, next state PREFILL.
REQ-018 in_ack SHALL be high exactly when state != IDLE, frame_start=0 and level<DEPTH; combinational from registered state.
REQ-019 PREFILL: accept writes, no pops, pix_out=UNDER_COLOUR; when level reaches THRESH -> STREAM next cycle.
REQ-020 STREAM with de=1 and level>0: pop one entry; pix_out SHALL present it on the next cycle (latency 1).
REQ-021 STREAM with de=1 and level=0: no pop; pix_out=UNDER_COLOUR next cycle; underflow_cnt increments; next state STARVED.
REQ-022 STARVED: no pops, writes still accepted, pix_out=UNDER_COLOUR while de; leaves only on frame_start.
REQ-023 pix_out SHALL be 8'h00 on the cycle after any cycle with de=0.
REQ-024 Simultaneous push and pop SHALL leave level unchanged and keep FIFO ordering; a push into an empty FIFO SHALL NOT fall through in the same cycle.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH or go below 0.
REQ-026 underflow_cnt SHALL saturate at 16'hFFFF and SHALL NOT clear on frame_start.

Reset
REQ-027 On rst_pix_n low, asynchronously: state=IDLE, pointers=0, level=0, pix_out=8'h00, underflow_cnt=0, in_ack=0.
REQ-028 Reset asserted mid-frame SHALL discard buffered pixels; after release the block SHALL wait in IDLE for frame_start.
REQ-029 FIFO storage array SHALL NOT require reset.

Structure
REQ-030 State enum and pixel width constant PIX_W=8 SHALL live in shared package ppu_pkg.
REQ-031 Storage and pointers SHALL live in sub-module sync_fifo (DEPTH, WIDTH parameters; push, pop, flush, rd_data, level); the state machine and output register SHALL remain in pix_stream_fifo.

Verification
REQ-032 Reset, then frame_start, push 8 pixels 8'h04..8'h0B -> STREAM after 8th push; de high 8 cycles -> pix_out 8'h04..8'h0B, each one cycle after its de.
REQ-033 Fill to 16 with in_stb held -> in_ack low at level=16; one de pop -> in_ack high next cycle, level returns to 16.
REQ-034 STREAM, empty, de=1 -> pix_out=8'hC0, underflow_cnt=1, state STARVED; later pushes do not restore streaming before frame_start.
REQ-035 frame_start with in_stb=1 and level=5 -> level=0, that pixel dropped, state PREFILL.
REQ-036 Run 40 push/pop cycles with simultaneous push and pop -> ordering preserved across pointer wrap, level constant.
REQ-037 Assert rst_pix_n low mid-STREAM between clock edges -> outputs reset immediately, IDLE held until frame_start.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared PPU-side types: pixel width and the pixel stream FIFO state encoding.
package ppu_pkg;

  localparam int unsigned PIX_W = 8;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPrefill = 2'd1,
    StStream  = 2'd2,
    StStarved = 2'd3
  } pix_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; storage is unreset, pointers and level are reset.
module sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] FullLvl = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  // Guard against overrun/underrun even if the caller misbehaves.
  assign do_push = push_i & (level_q != FullLvl) & ~flush_i;
  assign do_pop  = pop_i & (level_q != '0) & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign level_o   = level_q;

endmodule

// File: rtl/pix_stream_fifo.sv
// Pixel elastic buffer between PPU and VGA driver: prefill to a threshold, then stream on de.
module pix_stream_fifo
  import ppu_pkg::*;
#(
  parameter int unsigned     DEPTH        = 16,
  parameter int unsigned     THRESH       = 8,
  parameter logic [PIX_W-1:0] UNDER_COLOUR = 8'hC0
) (
  input  logic                   clk_pix,
  input  logic                   rst_pix_n,
  input  logic [PIX_W-1:0]       in_data,
  input  logic                   in_stb,
  output logic                   in_ack,
  input  logic                   frame_start,
  input  logic                   de,
  output logic [PIX_W-1:0]       pix_out,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            underflow_cnt,
  output logic [1:0]             state_o
);

  localparam int unsigned   LW        = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] DepthLvl  = LW'(DEPTH);
  localparam logic [LW-1:0] ThreshLvl = LW'(THRESH);

  pix_state_e       state_q, state_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic [15:0]      ucnt_q, ucnt_d;
  logic [PIX_W-1:0] rd_data;
  logic             push, pop;

  assign in_ack = (state_q != StIdle) & ~frame_start & (level < DepthLvl);
  assign push   = in_stb & in_ack;
  assign pop    = (state_q == StStream) & de & (level != '0) & ~frame_start;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PIX_W)
  ) u_fifo (
    .clk_i     (clk_pix),
    .rst_ni    (rst_pix_n),
    .push_i    (push),
    .wr_data_i (in_data),
    .pop_i     (pop),
    .flush_i   (frame_start),
    .rd_data_o (rd_data),
    .level_o   (level)
  );

  always_comb begin
    state_d = state_q;
    ucnt_d  = ucnt_q;
    // Blanking forces black; otherwise show the popped pixel or the underflow colour.
    if (!de)      pix_d = '0;
    else if (pop) pix_d = rd_data;
    else          pix_d = UNDER_COLOUR;

    if (frame_start) begin
      state_d = StPrefill;
    end else begin
      unique case (state_q)
        StIdle:    state_d = StIdle;
        StPrefill: if (level >= ThreshLvl) state_d = StStream;
        StStream: begin
          if (de && (level == '0)) begin
            state_d = StStarved;
            if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
          end
        end
        StStarved: state_d = StStarved;
      endcase
    end
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      state_q <= StIdle;
      pix_q   <= '0;
      ucnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      ucnt_q  <= ucnt_d;
    end
  end

  assign pix_out       = pix_q;
  assign underflow_cnt = ucnt_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_pix_stream_fifo.sv
// Self-checking bench for pix_stream_fifo against a queue-based reference model.
module tb_pix_stream_fifo;

  localparam int DEPTH = 16;
  localparam int THRESH = 8;
  localparam logic [7:0] UC = 8'hC0;

  logic       clk_pix, rst_pix_n;
  logic [7:0] in_data;
  logic       in_stb, in_ack, frame_start, de;
  logic [7:0] pix_out;
  logic [4:0] level;
  logic [15:0] underflow_cnt;
  logic [1:0] state_o;

  int n_tests = 0;
  int n_fail = 0;

  pix_stream_fifo #(
    .DEPTH        (DEPTH),
    .THRESH       (THRESH),
    .UNDER_COLOUR (UC)
  ) dut (
    .clk_pix       (clk_pix),
    .rst_pix_n     (rst_pix_n),
    .in_data       (in_data),
    .in_stb        (in_stb),
    .in_ack        (in_ack),
    .frame_start   (frame_start),
    .de            (de),
    .pix_out       (pix_out),
    .level         (level),
    .underflow_cnt (underflow_cnt),
    .state_o       (state_o)
  );

  initial clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  // Reference model: 0 idle, 1 prefill, 2 stream, 3 starved.
  int         m_state;
  logic [7:0] m_q[$];
  logic [7:0] m_pix;
  int         m_ucnt;

  function automatic logic model_ack();
    return (m_state != 0) && !frame_start && (m_q.size() < DEPTH);
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_q.delete();
    m_pix = 8'h00;
    m_ucnt = 0;
  endtask

  task automatic model_step();
    logic       ack;
    logic [7:0] v;
    int         old_n;
    ack   = model_ack();
    old_n = m_q.size();
    v     = UC;
    if (frame_start) begin
      m_q.delete();
      m_state = 1;
      m_pix = de ? UC : 8'h00;
    end else begin
      if (m_state == 2 && de && old_n > 0) v = m_q.pop_front();
      if (in_stb && ack) m_q.push_back(in_data);
      m_pix = de ? v : 8'h00;
      case (m_state)
        1: if (old_n >= THRESH) m_state = 2;
        2: if (de && old_n == 0) begin
             m_state = 3;
             if (m_ucnt < 65535) m_ucnt++;
           end
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic test_reset();
    rst_pix_n = 1'b0; in_stb = 1'b1; de = 1'b0; frame_start = 1'b0; in_data = 8'h55;
    model_reset();
    #12;
    n_tests++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state_o); end
    n_tests++; if (level !== 5'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
    n_tests++; if (pix_out !== 8'h00) begin n_fail++; $display("FAIL reset_pix got %h want 00", pix_out); end
    n_tests++; if (underflow_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_ucnt got %0d want 0", underflow_cnt); end
    n_tests++; if (in_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b want 0", in_ack); end
    @(negedge clk_pix); rst_pix_n = 1'b1;
    @(posedge clk_pix); #1;
    de = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (in_ack !== 1'b0) begin n_fail++; $display("FAIL idle_ack got %b want 0", in_ack); end
      tick();
      n_tests++; if (state_o !== 2'd0 || level !== 5'd0) begin
        n_fail++; $display("FAIL idle_hold state %0d level %0d want 0/0", state_o, level); end
      n_tests++; if (pix_out !== UC) begin n_fail++; $display("FAIL idle_pix got %h want %h", pix_out, UC); end
    end
    in_stb = 1'b0; de = 1'b0;
  endtask

  task automatic test_prefill_stream();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    n_tests++; if (state_o !== 2'd1) begin n_fail++; $display("FAIL prefill_enter got %0d want 1", state_o); end
    for (int i = 0; i < 8; i++) begin
      in_stb = 1'b1; in_data = 8'(4 + i);
      #1;
      n_tests++; if (in_ack !== 1'b1) begin n_fail++; $display("FAIL prefill_ack got %b want 1", in_ack); end
      tick();
    end
    in_stb = 1'b0;
    tick();
    n_tests++; if (state_o !== 2'd2) begin n_fail++; $display("FAIL stream_enter got %0d want 2", state_o); end
    n_tests++; if (level !== 5'd8) begin n_fail++; $display("FAIL prefill_level got %0d want 8", level); end
    for (int i = 0; i < 8; i++) begin
      de = 1'b1; tick();
      n_tests++; if (pix_out !== 8'(4 + i)) begin
        n_fail++; $display("FAIL stream_pix[%0d] got %h want %h", i, pix_out, 8'(4 + i)); end
    end
    de = 1'b0; tick();
    n_tests++; if (pix_out !== 8'h00) begin n_fail++; $display("FAIL blank_pix got %h want 00", pix_out); end
  endtask

  task automatic test_full();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    in_stb = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      in_data = 8'($urandom); tick();
    end
    #1;
    n_tests++; if (level !== 5'd16) begin n_fail++; $display("FAIL full_level got %0d want 16", level); end
    n_tests++; if (in_ack !== 1'b0) begin n_fail++; $display("FAIL full_ack got %b want 0", in_ack); end
    de = 1'b1; tick(); de = 1'b0;
    n_tests++; if (level !== 5'd15) begin n_fail++; $display("FAIL full_pop_level got %0d want 15", level); end
    n_tests++; if (pix_out !== m_pix) begin n_fail++; $display("FAIL full_pop_pix got %h want %h", pix_out, m_pix); end
    #1;
    n_tests++; if (in_ack !== 1'b1) begin n_fail++; $display("FAIL refill_ack got %b want 1", in_ack); end
    tick();
    n_tests++; if (level !== 5'd16) begin n_fail++; $display("FAIL refill_level got %0d want 16", level); end
    in_stb = 1'b0;
  endtask

  task automatic test_underflow();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    in_stb = 1'b1;
    for (int i = 0; i < THRESH; i++) begin in_data = 8'($urandom); tick(); end
    in_stb = 1'b0; tick();
    de = 1'b1;
    for (int i = 0; i < THRESH; i++) tick();
    tick();
    n_tests++; if (pix_out !== UC) begin n_fail++; $display("FAIL under_pix got %h want %h", pix_out, UC); end
    n_tests++; if (underflow_cnt !== 16'd1) begin n_fail++; $display("FAIL under_cnt got %0d want 1", underflow_cnt); end
    n_tests++; if (state_o !== 2'd3) begin n_fail++; $display("FAIL under_state got %0d want 3", state_o); end
    in_stb = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_data = 8'($urandom); tick();
      n_tests++; if (state_o !== 2'd3 || pix_out !== UC) begin
        n_fail++; $display("FAIL starved_hold state %0d pix %h want 3/%h", state_o, pix_out, UC); end
    end
    n_tests++; if (level !== 5'(m_q.size())) begin
      n_fail++; $display("FAIL starved_level got %0d want %0d", level, m_q.size()); end
    in_stb = 1'b0; de = 1'b0;
  endtask

  task automatic test_flush();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    in_stb = 1'b1;
    for (int i = 0; i < 5; i++) begin in_data = 8'($urandom); tick(); end
    n_tests++; if (level !== 5'd5) begin n_fail++; $display("FAIL flush_pre_level got %0d want 5", level); end
    frame_start = 1'b1; in_data = 8'hAA;
    #1;
    n_tests++; if (in_ack !== 1'b0) begin n_fail++; $display("FAIL flush_ack got %b want 0", in_ack); end
    tick(); frame_start = 1'b0; in_stb = 1'b0;
    n_tests++; if (level !== 5'd0) begin n_fail++; $display("FAIL flush_level got %0d want 0", level); end
    n_tests++; if (state_o !== 2'd1) begin n_fail++; $display("FAIL flush_state got %0d want 1", state_o); end
  endtask

  task automatic test_back_to_back();
    in_stb = 1'b1;
    for (int i = 0; i < THRESH; i++) begin in_data = 8'($urandom); tick(); end
    in_stb = 1'b0; tick();
    in_stb = 1'b1; de = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_data = 8'($urandom); tick();
      n_tests++; if (level !== 5'd8) begin n_fail++; $display("FAIL b2b_level[%0d] got %0d want 8", i, level); end
      n_tests++; if (pix_out !== m_pix) begin
        n_fail++; $display("FAIL b2b_pix[%0d] got %h want %h", i, pix_out, m_pix); end
    end
    in_stb = 1'b0; de = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      frame_start = ($urandom_range(0, 29) == 0);
      in_stb = ($urandom_range(0, 3) != 0);
      de = ($urandom_range(0, 2) != 0);
      in_data = 8'($urandom);
      #1;
      n_tests++; if (in_ack !== model_ack()) begin
        n_fail++; $display("FAIL rnd_ack[%0d] got %b want %b", i, in_ack, model_ack()); end
      tick();
      n_tests++; if (state_o !== 2'(m_state)) begin
        n_fail++; $display("FAIL rnd_state[%0d] got %0d want %0d", i, state_o, m_state); end
      n_tests++; if (level !== 5'(m_q.size())) begin
        n_fail++; $display("FAIL rnd_level[%0d] got %0d want %0d", i, level, m_q.size()); end
      n_tests++; if (pix_out !== m_pix) begin
        n_fail++; $display("FAIL rnd_pix[%0d] got %h want %h", i, pix_out, m_pix); end
      n_tests++; if (underflow_cnt !== 16'(m_ucnt)) begin
        n_fail++; $display("FAIL rnd_ucnt[%0d] got %0d want %0d", i, underflow_cnt, m_ucnt); end
    end
    frame_start = 1'b0; in_stb = 1'b0; de = 1'b0;
  endtask

  task automatic test_async_reset();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    in_stb = 1'b1;
    for (int i = 0; i < 10; i++) begin in_data = 8'($urandom); tick(); end
    in_stb = 1'b0; tick();
    de = 1'b1; tick(); tick();
    #2 rst_pix_n = 1'b0;
    #1;
    model_reset();
    n_tests++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL areset_state got %0d want 0", state_o); end
    n_tests++; if (level !== 5'd0) begin n_fail++; $display("FAIL areset_level got %0d want 0", level); end
    n_tests++; if (pix_out !== 8'h00) begin n_fail++; $display("FAIL areset_pix got %h want 00", pix_out); end
    n_tests++; if (underflow_cnt !== 16'd0) begin n_fail++; $display("FAIL areset_ucnt got %0d want 0", underflow_cnt); end
    n_tests++; if (in_ack !== 1'b0) begin n_fail++; $display("FAIL areset_ack got %b want 0", in_ack); end
    @(negedge clk_pix); rst_pix_n = 1'b1;
    @(posedge clk_pix); #1;
    in_stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'($urandom); tick();
      n_tests++; if (state_o !== 2'd0 || level !== 5'd0) begin
        n_fail++; $display("FAIL post_reset_idle state %0d level %0d want 0/0", state_o, level); end
    end
    in_stb = 1'b0; de = 1'b0;
  endtask

  initial begin
    rst_pix_n = 1'b0; in_stb = 1'b0; de = 1'b0; frame_start = 1'b0; in_data = 8'h00;
    test_reset();
    test_prefill_stream();
    test_full();
    test_underflow();
    test_flush();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
